frame_rx: RTL and testbench



---
 rtl/frame_rx.sv | 143 ++++++++++++++
 tb/tb_frame_rx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_rx.sv
// frame_rx: fast-serial frame deserializer.
//
// Receives a one-bit-per-clock frame on rx:
//   start bit (0), then 48 data bits LSB first, then a stop bit (1).
// The 48-bit word is laid out as
//   [7:0]   address
//   [15:8]  opcode
//   [47:16] payload
// A frame whose address matches MY_ADDR or BCAST_ADDR is presented on
// addr/opcode/payload together with a one-cycle frame_valid strobe.
// A bad stop bit raises a one-cycle err strobe. The receiver then waits
// for the line to return high before it looks for another start bit.
//
// Ports:
//   clk         system clock
//   nRst        asynchronous active-low reset
//   rx          serial input, synchronous to clk, idles high
//   frame_valid one-cycle strobe: a new accepted frame is on the outputs
//   addr        address field of the last accepted frame
//   opcode      opcode field of the last accepted frame
//   payload     data field of the last accepted frame
//   busy        high whenever the receiver is not idle
//   err         one-cycle strobe on a framing (stop-bit) error
//   frame_cnt   accepted-frame count, wraps from 255 to 0
//   err_cnt     framing-error count, saturates at 255
module frame_rx #(
  parameter logic [7:0] MY_ADDR    = 8'h01,
  parameter logic [7:0] BCAST_ADDR = 8'hFF
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        rx,
  output logic        frame_valid,
  output logic [7:0]  addr,
  output logic [7:0]  opcode,
  output logic [31:0] payload,
  output logic        busy,
  output logic        err,
  output logic [7:0]  frame_cnt,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_STOP,
    S_RESYNC
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [47:0] r_shift;
  logic [5:0]  r_cnt;
  logic        w_addr_hit;
  logic        w_accept;
  logic        w_ferr;

  // The address is checked only once the whole word has been assembled.
  assign w_addr_hit = (r_shift[7:0] == MY_ADDR) || (r_shift[7:0] == BCAST_ADDR);

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_ferr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!rx) begin
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == 6'd47) begin
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (rx) begin
          // A good stop bit with a foreign address is dropped silently.
          w_accept     = w_addr_hit;
          w_state_next = S_IDLE;
        end else begin
          w_ferr       = 1'b1;
          w_state_next = S_RESYNC;
        end
      end
      S_RESYNC: begin
        // A low line here is the tail of a broken frame, not a start bit.
        if (rx) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_shift     <= 48'd0;
      r_cnt       <= 6'd0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
      addr        <= 8'd0;
      opcode      <= 8'd0;
      payload     <= 32'd0;
      frame_cnt   <= 8'd0;
      err_cnt     <= 8'd0;
    end else begin
      frame_valid <= w_accept;
      err         <= w_ferr;

      if ((r_state == S_IDLE) && !rx) begin
        r_cnt <= 6'd0;
      end else if (r_state == S_DATA) begin
        r_shift[r_cnt] <= rx;
        r_cnt          <= r_cnt + 6'd1;
      end

      if (w_accept) begin
        addr      <= r_shift[7:0];
        opcode    <= r_shift[15:8];
        payload   <= r_shift[47:16];
        frame_cnt <= frame_cnt + 8'd1;
      end

      if (w_ferr && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_frame_rx.sv
// Testbench for frame_rx: randomized frames, a reference model that
// predicts every strobe, and a monitor that checks strobes as they occur.
module tb_frame_rx;

  localparam logic [7:0] MY    = 8'h01;
  localparam logic [7:0] BCAST = 8'hFF;

  logic        clk;
  logic        nRst;
  logic        rx;
  logic        frame_valid;
  logic [7:0]  addr;
  logic [7:0]  opcode;
  logic [31:0] payload;
  logic        busy;
  logic        err;
  logic [7:0]  frame_cnt;
  logic [7:0]  err_cnt;

  frame_rx #(.MY_ADDR(MY), .BCAST_ADDR(BCAST)) dut (
    .clk        (clk),
    .nRst       (nRst),
    .rx         (rx),
    .frame_valid(frame_valid),
    .addr       (addr),
    .opcode     (opcode),
    .payload    (payload),
    .busy       (busy),
    .err        (err),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    bit          is_err;
    logic [7:0]  a;
    logic [7:0]  o;
    logic [31:0] p;
    logic [7:0]  fc;
    logic [7:0]  ec;
    int          at_edge;
  } exp_t;

  exp_t q[$];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: what the outputs and counters should hold.
  logic [7:0]  m_fcnt;
  logic [7:0]  m_ecnt;
  logic [7:0]  m_a;
  logic [7:0]  m_o;
  logic [31:0] m_p;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, req);
  endtask

  task automatic model_reset();
    m_fcnt = 8'd0;
    m_ecnt = 8'd0;
    m_a    = 8'd0;
    m_o    = 8'd0;
    m_p    = 32'd0;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    @(posedge clk);
    #1;
  endtask

  // One frame; stop=0 makes a framing error followed by extra_low low
  // cycles and one high cycle; gap idle-high cycles follow.
  task automatic send_frame(input logic [7:0] a, input logic [7:0] o, input logic [31:0] p,
                            input logic stop, input int extra_low, input int gap);
    logic [47:0] w;
    int          start_e;
    exp_t        e;
    w = {p, o, a};
    send_bit(1'b0);
    start_e = edge_n;
    e.at_edge = start_e + 49;
    if (stop) begin
      if (a == MY || a == BCAST) begin
        m_fcnt = m_fcnt + 8'd1;
        m_a = a; m_o = o; m_p = p;
        e.is_err = 1'b0; e.a = m_a; e.o = m_o; e.p = m_p; e.fc = m_fcnt; e.ec = m_ecnt;
        q.push_back(e);
      end
    end else begin
      m_ecnt = (m_ecnt == 8'hFF) ? 8'hFF : m_ecnt + 8'd1;
      e.is_err = 1'b1; e.a = m_a; e.o = m_o; e.p = m_p; e.fc = m_fcnt; e.ec = m_ecnt;
      q.push_back(e);
    end
    for (int i = 0; i < 48; i++) send_bit(w[i]);
    send_bit(stop);
    if (!stop) begin
      repeat (extra_low) send_bit(1'b0);
      send_bit(1'b1);
    end
    repeat (gap) send_bit(1'b1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
  endtask

  function automatic logic [7:0] rand_foreign();
    logic [7:0] a;
    a = 8'($urandom_range(2, 254));
    return a;
  endfunction

  // Monitor: every strobe must match the oldest predicted event.
  always @(negedge clk) begin
    if (nRst && (frame_valid || err)) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe", {62'd0, frame_valid, err}, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        $display("event at edge %0d: %s addr=%02h op=%02h pay=%08h fcnt=%0d ecnt=%0d",
                 edge_n, err ? "err" : "frame", addr, opcode, payload, frame_cnt, err_cnt);
        chk("strobe_edge", 64'(edge_n), 64'(e.at_edge));
        chk("frame_valid", {63'd0, frame_valid}, {63'd0, !e.is_err});
        chk("err", {63'd0, err}, {63'd0, e.is_err});
        chk("addr", {56'd0, addr}, {56'd0, e.a});
        chk("opcode", {56'd0, opcode}, {56'd0, e.o});
        chk("payload", {32'd0, payload}, {32'd0, e.p});
        chk("frame_cnt", {56'd0, frame_cnt}, {56'd0, e.fc});
        chk("err_cnt", {56'd0, err_cnt}, {56'd0, e.ec});
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    int         kind;

    // 1: reset and idle
    rx = 1'b1;
    nRst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 nRst = 1'b1;
    repeat (10) send_bit(1'b1);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_frame_valid", {63'd0, frame_valid}, 64'd0);
    chk("reset_err", {63'd0, err}, 64'd0);
    chk("reset_addr", {56'd0, addr}, 64'd0);
    chk("reset_opcode", {56'd0, opcode}, 64'd0);
    chk("reset_payload", {32'd0, payload}, 64'd0);
    chk("reset_frame_cnt", {56'd0, frame_cnt}, 64'd0);
    chk("reset_err_cnt", {56'd0, err_cnt}, 64'd0);

    // 2: one accepted frame
    send_frame(8'h01, 8'h03, 32'hDEADBEEF, 1'b1, 0, 2);
    drain();
    chk("t2_frame_cnt", {56'd0, frame_cnt}, 64'd1);

    // 3: mismatch then broadcast, back to back
    send_frame(8'h05, 8'h11, 32'hCAFEF00D, 1'b1, 0, 0);
    send_frame(8'hFF, 8'h22, 32'h12345678, 1'b1, 0, 2);
    drain();
    chk("t3_payload", {32'd0, payload}, 64'h12345678);
    chk("t3_frame_cnt", {56'd0, frame_cnt}, {56'd0, m_fcnt});

    // 4: bad stop bit, long low tail, then a good frame
    send_frame(8'h01, 8'h44, 32'hAAAA5555, 1'b0, 5, 0);
    send_bit(1'b1);
    chk("t4_idle_after_resync", {63'd0, busy}, 64'd0);
    send_frame(8'h01, 8'h55, 32'h0BADC0DE, 1'b1, 0, 2);
    drain();
    chk("t4_err_cnt", {56'd0, err_cnt}, 64'd1);

    // 5: reset during data bit 20
    send_bit(1'b0);
    for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)));
    chk("t5_busy_midframe", {63'd0, busy}, 64'd1);
    nRst = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_busy", {63'd0, busy}, 64'd0);
    chk("t5_rst_payload", {32'd0, payload}, 64'd0);
    chk("t5_rst_frame_cnt", {56'd0, frame_cnt}, 64'd0);
    chk("t5_rst_err_cnt", {56'd0, err_cnt}, 64'd0);
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1 nRst = 1'b1;
    send_bit(1'b1);
    send_frame(8'h01, 8'h66, 32'h13579BDF, 1'b1, 0, 2);
    drain();
    chk("t5_frame_cnt", {56'd0, frame_cnt}, 64'd1);

    // Random mix of accepted, foreign and broken frames
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: a = MY;
        1: a = BCAST;
        default: a = rand_foreign();
      endcase
      if (kind == 3)
        send_frame(a, 8'($urandom), $urandom, 1'b0, $urandom_range(0, 3), $urandom_range(0, 2));
      else
        send_frame(a, 8'($urandom), $urandom, 1'b1, 0, $urandom_range(0, 2));
    end
    drain();

    // 6: counter wrap and saturation from a clean reset
    nRst = 1'b0;
    model_reset();
    #1;
    rx = 1'b1;
    @(posedge clk);
    #1 nRst = 1'b1;
    send_bit(1'b1);
    for (int n = 0; n < 256; n++)
      send_frame(($urandom_range(0, 1) != 0) ? MY : BCAST, 8'($urandom), $urandom, 1'b1, 0,
                 $urandom_range(0, 1));
    for (int n = 0; n < 260; n++)
      send_frame(rand_foreign(), 8'($urandom), $urandom, 1'b0, $urandom_range(0, 2), 0);
    send_bit(1'b1);
    drain();
    chk("t6_frame_cnt_wrapped", {56'd0, frame_cnt}, 64'd0);
    chk("t6_err_cnt_saturated", {56'd0, err_cnt}, 64'd255);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
